// File: rtl/kws_act_unit.sv
// kws_act_unit
// Multi-lane activation engine behind a Wishbone slave register window.
// Words written to DIN go through an input FIFO and a one-stage per-lane
// activation (bypass / ReLU / leaky ReLU / clipped ReLU). Results land in an
// output FIFO that is read through DOUT. Each 32-bit word holds 32/ELEM_W
// signed lanes.
//
// Build option: define KWS_ACT_PERF_EN to build the PERF counter (lanes
// forced to zero plus lanes clamped to CLIP). Without it PERF reads 0.
//
// Ports:
//   clk          single clock
//   rst_n        asynchronous active-low reset
//   wbs_stb_i    Wishbone strobe
//   wbs_cyc_i    Wishbone cycle
//   wbs_we_i     write enable
//   wbs_sel_i    byte selects (ignored, full-word access only)
//   wbs_dat_i    write data
//   wbs_adr_i    byte address
//   wbs_ack_o    one-cycle acknowledge pulse
//   wbs_dat_o    read data, valid while wbs_ack_o is high
//   irq_o        level irq: output FIFO non-empty or a sticky error set
module kws_act_unit #(
  parameter int unsigned ELEM_W     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam int unsigned LANES = 32 / ELEM_W;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;

  // ---------------- bus decode ----------------
  logic       hit, acc;
  logic [2:0] reg_idx;
  logic       wr_ctrl, din_push, dout_req, wr_status, wr_clip, wr_perf, flush;

  assign hit       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  // acc marks the edge that raises ack; all side effects are applied there once
  assign acc       = hit & ~wbs_ack_o;
  assign reg_idx   = wbs_adr_i[4:2];
  assign wr_ctrl   = acc &  wbs_we_i & (reg_idx == 3'd0);
  assign din_push  = acc &  wbs_we_i & (reg_idx == 3'd1);
  assign dout_req  = acc & ~wbs_we_i & (reg_idx == 3'd2);
  assign wr_status = acc &  wbs_we_i & (reg_idx == 3'd3);
  assign wr_clip   = acc &  wbs_we_i & (reg_idx == 3'd4);
  assign wr_perf   = acc &  wbs_we_i & (reg_idx == 3'd5);
  assign flush     = wr_ctrl & wbs_dat_i[31];

  // ---------------- state ----------------
  logic [7:0]               ctrl_q;
  logic signed [ELEM_W-1:0] clip_q;
  logic                     ovf_q, unf_q;

  logic [31:0]   in_mem  [FIFO_DEPTH];
  logic [31:0]   out_mem [FIFO_DEPTH];
  logic [AW-1:0] in_wp, in_rp, out_wp, out_rp;
  logic [CW-1:0] in_cnt, out_cnt;

  logic          inflight;
  logic [31:0]   infl_word;

  // ---------------- engine control ----------------
  logic        in_full, out_empty, fire, push_ok, out_pop;
  logic [CW:0] out_occ;

  assign in_full   = (in_cnt == CW'(FIFO_DEPTH));
  assign out_empty = (out_cnt == '0);
  // the inflight word already owns an output slot
  assign out_occ   = {1'b0, out_cnt} + {{CW{1'b0}}, inflight};
  assign fire      = (in_cnt != '0) && (out_occ < (CW+1)'(FIFO_DEPTH));
  // a pop in the same cycle frees the slot, so a push on a full FIFO is kept
  assign push_ok   = din_push & (~in_full | fire);
  assign out_pop   = dout_req & ~out_empty;

  // ---------------- per-lane activation ----------------
  logic [31:0]              in_head;
  logic signed [ELEM_W-1:0] lane_x, lane_r;
  logic                     lane_zero, lane_clamp;
  logic [31:0]              act_word;
  logic [2:0]               act_hits;

  assign in_head = in_mem[in_rp];

  always_comb begin
    act_word   = '0;
    act_hits   = '0;
    lane_x     = '0;
    lane_r     = '0;
    lane_zero  = 1'b0;
    lane_clamp = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      lane_x = in_head[i*ELEM_W +: ELEM_W];
      case (ctrl_q[3:0])
        4'h5: lane_r = lane_x[ELEM_W-1] ? '0 : lane_x;
        4'h6: lane_r = lane_x[ELEM_W-1] ? (lane_x >>> ctrl_q[7:4]) : lane_x;
        4'h7: begin
          // a negative ceiling clamps everything to zero
          if (lane_x[ELEM_W-1] || clip_q[ELEM_W-1]) lane_r = '0;
          else if (lane_x > clip_q)                 lane_r = clip_q;
          else                                      lane_r = lane_x;
        end
        default: lane_r = lane_x;
      endcase
      lane_zero  = (lane_r == '0) && (lane_x != '0);
      lane_clamp = (ctrl_q[3:0] == 4'h7) && !lane_zero && !clip_q[ELEM_W-1] &&
                   (lane_x > clip_q);
      act_hits   = act_hits + {2'b00, lane_zero | lane_clamp};
      act_word[i*ELEM_W +: ELEM_W] = lane_r;
    end
  end

  // ---------------- FIFO storage ----------------
  always_ff @(posedge clk) begin
    if (push_ok)  in_mem[in_wp]   <= wbs_dat_i;
    if (inflight) out_mem[out_wp] <= infl_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_wp  <= '0;
      in_rp  <= '0;
      in_cnt <= '0;
    end else if (flush) begin
      in_wp  <= '0;
      in_rp  <= '0;
      in_cnt <= '0;
    end else begin
      if (push_ok) in_wp <= in_wp + 1'b1;
      if (fire)    in_rp <= in_rp + 1'b1;
      case ({push_ok, fire})
        2'b10:   in_cnt <= in_cnt + 1'b1;
        2'b01:   in_cnt <= in_cnt - 1'b1;
        default: in_cnt <= in_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight  <= 1'b0;
      infl_word <= '0;
    end else if (flush) begin
      inflight  <= 1'b0;
    end else begin
      inflight <= fire;
      if (fire) infl_word <= act_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wp  <= '0;
      out_rp  <= '0;
      out_cnt <= '0;
    end else if (flush) begin
      out_wp  <= '0;
      out_rp  <= '0;
      out_cnt <= '0;
    end else begin
      if (inflight) out_wp <= out_wp + 1'b1;
      if (out_pop)  out_rp <= out_rp + 1'b1;
      case ({inflight, out_pop})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // ---------------- configuration / sticky errors ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      clip_q <= {1'b0, {(ELEM_W-1){1'b1}}};
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= wbs_dat_i[7:0];
      if (wr_clip) clip_q <= wbs_dat_i[ELEM_W-1:0];
      // a new event wins over a same-cycle clear
      ovf_q <= (din_push & in_full & ~fire) | (ovf_q & ~(wr_status & wbs_dat_i[24]));
      unf_q <= (dout_req & out_empty)       | (unf_q & ~(wr_status & wbs_dat_i[25]));
    end
  end

  // ---------------- performance counter ----------------
  logic [31:0] perf_rd;
`ifdef KWS_ACT_PERF_EN
  logic [31:0] perf_q;
  logic [32:0] perf_sum;

  assign perf_sum = {1'b0, perf_q} + {30'd0, act_hits};
  assign perf_rd  = perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              perf_q <= '0;
    else if (wr_perf)        perf_q <= '0;
    else if (fire && !flush) perf_q <= perf_sum[32] ? '1 : perf_sum[31:0];
  end
`else
  logic unused_perf;
  assign unused_perf = ^{act_hits, wr_perf};
  assign perf_rd     = '0;
`endif

  // ---------------- read mux / bus outputs ----------------
  logic [31:0] status_w, rdata;

  always_comb begin
    status_w            = '0;
    status_w[CW-1:0]    = in_cnt;
    status_w[8 +: CW]   = out_cnt;
    status_w[16]        = in_full;
    status_w[17]        = out_empty;
    status_w[24]        = ovf_q;
    status_w[25]        = unf_q;
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      3'd0: rdata[7:0] = ctrl_q;
      3'd2: rdata = out_empty ? '0 : out_mem[out_rp];
      3'd3: rdata = status_w;
      3'd4: rdata[ELEM_W-1:0] = clip_q;
      3'd5: rdata = perf_rd;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= (acc && !wbs_we_i) ? rdata : '0;
    end
  end

  assign irq_o = ~out_empty | ovf_q | unf_q;

  logic unused_bus;
  assign unused_bus = ^{wbs_sel_i, wbs_adr_i[1:0]};

endmodule

// File: tb/tb_kws_act_unit.sv
module tb_kws_act_unit;

  localparam int          EW    = 16;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_DIN    = BASE + 32'h04;
  localparam logic [31:0] A_DOUT   = BASE + 32'h08;
  localparam logic [31:0] A_STATUS = BASE + 32'h0C;
  localparam logic [31:0] A_CLIP   = BASE + 32'h10;
  localparam logic [31:0] A_PERF   = BASE + 32'h14;

  logic        clk, rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_w, adr, dat_r;
  logic        ack, irq;

  kws_act_unit #(.ELEM_W(EW), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat_w), .wbs_adr_i(adr),
    .wbs_ack_o(ack), .wbs_dat_o(dat_r), .irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [31:0] exp_q[$];
  logic [3:0]  cur_op;
  int          cur_sh;
  logic [31:0] cur_clip;
  longint      perf_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  // Lane activation from the arithmetic definitions; hits = lanes zeroed or clamped.
  function automatic logic [31:0] act_model(input logic [31:0] w, input logic [3:0] op,
                                            input int sh, input logic [31:0] clipw,
                                            output int hits);
    longint half, full, c, x, r, d;
    logic [31:0] res;
    half = longint'(1) << (EW - 1);
    full = half * 2;
    c = longint'(clipw) & (full - 1);
    if (c >= half) c = c - full;
    res  = '0;
    hits = 0;
    for (int i = 0; i < 32 / EW; i++) begin
      x = (longint'(w) >> (i * EW)) & (full - 1);
      if (x >= half) x = x - full;
      r = x;
      if (op == 4'h5) begin
        if (x < 0) r = 0;
      end else if (op == 4'h6) begin
        if (x < 0) begin
          d = longint'(1) << sh;
          r = x / d;
          if (r * d != x) r = r - 1;   // floor toward -inf
        end
      end else if (op == 4'h7) begin
        if (c < 0 || x < 0) r = 0;
        else if (x > c)     r = c;
      end
      if (x != 0 && r == 0) hits++;
      else if (op == 4'h7 && c >= 0 && x > c) hits++;
      res = res | 32'((r & (full - 1)) << (i * EW));
    end
    return res;
  endfunction

  task automatic wb_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rdat, input bit b2b);
    bit got;
    if (!b2b) begin
      @(posedge clk);
      #1;
    end
    stb = 1'b1; cyc = 1'b1; we = wr; adr = a; dat_w = d;
    got  = 1'b0;
    rdat = '0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        got  = 1'b1;
        rdat = dat_r;
      end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    if (!got) check("ack_timeout", 32'(got), 32'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    wb_xfer(1'b1, a, d, dummy, 1'b0);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    wb_xfer(1'b0, a, 32'd0, v, 1'b0);
    check(tag, v, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [3:0] op, input int sh);
    cur_op = op;
    cur_sh = sh;
    wr(A_CTRL, {24'd0, 4'(sh), op});
  endtask

  task automatic set_clip(input logic [31:0] c);
    cur_clip = c;
    wr(A_CLIP, c);
  endtask

  task automatic push(input logic [31:0] w, input bit b2b);
    int h;
    logic [31:0] dummy;
    exp_q.push_back(act_model(w, cur_op, cur_sh, cur_clip, h));
    perf_exp += h;
    wb_xfer(1'b1, A_DIN, w, dummy, b2b);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    logic [31:0] v;
    wb_xfer(1'b0, A_DOUT, 32'd0, v, 1'b0);
    check(tag, v, exp);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  task automatic pop_model(input string tag);
    logic [31:0] v;
    logic [31:0] e;
    wb_xfer(1'b0, A_DOUT, 32'd0, v, 1'b0);
    e = exp_q.pop_front();
    check(tag, v, e);
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur_op   = 4'h0;
    cur_sh   = 0;
    cur_clip = 32'h0000_7FFF;
    perf_exp = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (%0d/%0d)", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  logic [31:0] w;
  logic [3:0]  op;
  int          n;
  bit          got;

  initial begin
    stb = 0; cyc = 0; we = 0; sel = 4'hF; dat_w = 0; adr = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", dat_r, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    rd_chk("rst_status", A_STATUS, 32'h0002_0000);
    rd_chk("rst_ctrl",   A_CTRL,   32'h0000_0000);
    rd_chk("rst_clip",   A_CLIP,   32'h0000_7FFF);
    rd_chk("rst_perf",   A_PERF,   32'h0000_0000);
    wr(BASE + 32'h1C, 32'hFFFF_FFFF);
    rd_chk("unmapped_rd", BASE + 32'h1C, 32'h0000_0000);

    // address outside the window must never be acknowledged
    @(posedge clk); #1;
    stb = 1; cyc = 1; we = 1; adr = BASE + 32'h20; dat_w = 32'h1234;
    got = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (ack) got = 1;
    end
    stb = 0; cyc = 0; we = 0;
    check("oow_no_ack", 32'(got), 32'd0);
    rd_chk("oow_status", A_STATUS, 32'h0002_0000);

    // ReLU and the PERF counter
    set_mode(4'h5, 0);
    push(32'hFFFF_FFFF, 1'b0);
    push(32'h8000_0001, 1'b0);
    idle(2);
`ifdef KWS_ACT_PERF_EN
    rd_chk("perf_relu", A_PERF, 32'd3);
`else
    rd_chk("perf_off", A_PERF, 32'd0);
`endif
    wr(A_PERF, 32'h0);
    perf_exp = 0;
    rd_chk("perf_clr", A_PERF, 32'd0);
    pop_chk("relu_allneg", 32'h0000_0000);
    pop_chk("relu_min",    32'h0000_0001);

    push(32'hFFFB_0005, 1'b0);
    idle(2);
    rd_chk("relu_status", A_STATUS, 32'h0000_0100);
    check("irq_data", 32'(irq), 32'd1);
    pop_chk("relu", 32'h0000_0005);
    rd_chk("relu_status_empty", A_STATUS, 32'h0002_0000);
    check("irq_idle", 32'(irq), 32'd0);

    // leaky
    set_mode(4'h6, 1);
    rd_chk("ctrl_rb", A_CTRL, 32'h0000_0016);
    push(32'hFFFC_0004, 1'b0);
    push(32'hFFFF_0000, 1'b0);
    idle(2);
    pop_chk("leaky_m4", 32'hFFFE_0004);
    pop_chk("leaky_m1", 32'hFFFF_0000);

    // clip
    set_mode(4'h7, 0);
    set_clip(32'h0000_0006);
    push(32'h0009_0003, 1'b0);
    push(32'h8000_7FFF, 1'b0);
    idle(2);
    pop_chk("clip_a", 32'h0006_0003);
    pop_chk("clip_b", 32'h0000_0006);

    // undefined opcode acts as bypass
    set_mode(4'h3, 0);
    push(32'hFFFB_0005, 1'b0);
    idle(2);
    pop_chk("bypass_op3", 32'hFFFB_0005);

    // randomized modes and data against the model
    for (int r = 0; r < 25; r++) begin
      case ($urandom_range(0, 4))
        0:       op = 4'h0;
        1:       op = 4'h5;
        2:       op = 4'h6;
        3:       op = 4'h7;
        default: op = 4'($urandom_range(8, 15));
      endcase
      set_mode(op, int'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) set_clip({16'd0, 16'($urandom)});
      else                           set_clip({16'd0, 16'($urandom_range(0, 16'h7FFF))});
      n = int'($urandom_range(1, 6));
      for (int j = 0; j < n; j++) begin
        w = $urandom;
        push(w, 1'b0);
      end
      idle(2);
      while (exp_q.size() > 0) pop_model("rand");
    end
`ifdef KWS_ACT_PERF_EN
    rd_chk("perf_model", A_PERF, 32'(perf_exp));
`else
    rd_chk("perf_model_off", A_PERF, 32'd0);
`endif

    // capacity, overflow, push accepted alongside a pop, underflow
    set_mode(4'h5, 0);
    for (int i = 1; i <= 16; i++) push(32'(i), 1'b0);
    wr(A_DIN, 32'd17);
    idle(2);
    rd_chk("ovf_status", A_STATUS, 32'h0101_0808);
    check("irq_ovf", 32'(irq), 32'd1);
    wr(A_STATUS, 32'h0100_0000);
    rd_chk("ovf_w1c", A_STATUS, 32'h0001_0808);
    pop_chk("order_1", 32'd1);
    push(32'd100, 1'b1);
    idle(2);
    rd_chk("simul_push_pop", A_STATUS, 32'h0001_0808);
    for (int i = 2; i <= 16; i++) pop_chk("order", 32'(i));
    pop_chk("order_last", 32'd100);
    pop_chk("unf_data", 32'd0);
    rd_chk("unf_status", A_STATUS, 32'h0202_0000);
    wr(A_STATUS, 32'h0300_0000);
    rd_chk("sticky_clr", A_STATUS, 32'h0002_0000);
    check("irq_clear", 32'(irq), 32'd0);

    // flush keeps sticky bits
    pop_chk("unf_again", 32'd0);
    push(32'h0001_0002, 1'b0);
    push(32'h0003_0004, 1'b0);
    push(32'h0005_0006, 1'b0);
    idle(2);
    wr(A_CTRL, 32'h8000_0005);
    exp_q.delete();
    rd_chk("flush_status", A_STATUS, 32'h0202_0000);
    rd_chk("flush_ctrl",   A_CTRL,   32'h0000_0005);
    wr(A_STATUS, 32'h0300_0000);
    rd_chk("flush_clr", A_STATUS, 32'h0002_0000);

    // reset in the middle of an acknowledged read
    for (int i = 0; i < 4; i++) push(32'h0010_0000 + 32'(i), 1'b0);
    idle(3);
    @(posedge clk); #1;
    stb = 1; cyc = 1; we = 0; adr = A_STATUS;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge clk); #1;
      if (ack) got = 1;
    end
    check("rst_mid_ack_seen", 32'(got), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ack", 32'(ack), 32'd0);
    check("rst_mid_dat", dat_r, 32'd0);
    check("rst_mid_irq", 32'(irq), 32'd0);
    stb = 0; cyc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_chk("post_rst_status", A_STATUS, 32'h0002_0000);
    pop_chk("post_rst_dout", 32'd0);
    rd_chk("post_rst_unf", A_STATUS, 32'h0202_0000);
    check("post_rst_irq", 32'(irq), 32'd1);
    rd_chk("post_rst_ctrl", A_CTRL, 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
